serial_subtractor: RTL and testbench

- Bit-serial ripple-borrow subtractor. Computes diff = a - b - bin over WIDTH bits, LSB first, using one full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart to the team's combinational full-adder/half-adder arithmetic. It trades latency for area in the datapath.
- Operands load in parallel on a start handshake. The result presents in parallel with a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial ripple-borrow subtractor, diff = a - b - bin, LSB first.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;

    assign w_x       = r_a_sr[0];
    assign w_y       = r_b_sr[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_last    = (r_cnt == c_last_bit);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // The minuend register doubles as the result shift register: each consumed
    // LSB frees an MSB slot that receives the new difference bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_br   <= bin;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a_sr <= {w_d, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff       <= {w_d, r_a_sr[WIDTH-1:1]};
                        r_borrow_out <= w_br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Reference: an accepted operation occupies the unit for W+1 further edges;
    // the result appears, with the done pulse, after the W-th of them.
    int           m_rem  = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo   = 1'b0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic         m_bin  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bo = 1'b0;
        end else begin
            if (m_rem == 0) begin
                if (start) begin
                    m_a = a; m_b = b; m_bin = bin; m_rem = W + 1;
                end
            end else begin
                m_rem = m_rem - 1;
            end
            m_busy = (m_rem != 0);
            m_done = (m_rem == 1);
            if (m_rem == 1) begin
                int t;
                t      = int'(m_a) - int'(m_b) - int'(m_bin);
                m_diff = t[W-1:0];
                m_bo   = (int'(m_a) < int'(m_b) + int'(m_bin));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("diff", 32'(diff), 32'(m_diff));
        check("borrow_out", 32'(borrow_out), 32'(m_bo));
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
    endtask

    // Returns the cycle index (1 = cycle after the accept edge) where done is seen.
    task automatic wait_done(input bit noise, output int lat);
        logic [31:0] r;
        lat = 1;
        while (!done && lat < 4 * W) begin
            if (noise) begin
                r = $urandom;
                start = r[31]; a = r[W-1:0]; b = r[2*W-1:W]; bin = r[30];
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        int last;
        int pulses;
        logic [31:0] r;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ebin;
        int t;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        rst = 1'b0;

        start_op(8'h05, 8'h03, 1'b0);
        wait_done(1'b0, lat);
        check("lat_05_03", 32'(lat), 32'(W + 1));
        check("diff_05_03", 32'(diff), 32'h02);
        check("bo_05_03", 32'(borrow_out), 32'd0);

        start_op(8'h03, 8'h05, 1'b0);
        wait_done(1'b0, lat);
        check("diff_03_05", 32'(diff), 32'hFE);
        check("bo_03_05", 32'(borrow_out), 32'd1);

        start_op(8'h00, 8'h00, 1'b1);
        wait_done(1'b0, lat);
        check("diff_00_00_1", 32'(diff), 32'hFF);
        check("bo_00_00_1", 32'(borrow_out), 32'd1);

        start_op(8'hFF, 8'hFF, 1'b0);
        wait_done(1'b0, lat);
        check("diff_FF_FF", 32'(diff), 32'h00);
        check("bo_FF_FF", 32'(borrow_out), 32'd0);

        // start while busy must be ignored
        start_op(8'h80, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat);
        check("diff_busy_start", 32'(diff), 32'h7F);
        check("bo_busy_start", 32'(borrow_out), 32'd0);
        n = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n++;
        end
        check("extra_done", 32'(n), 32'd0);

        // asynchronous abort mid-operation
        start_op(8'h55, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_diff", 32'(diff), 32'd0);
        check("arst_bo", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) n++;
        end
        check("done_after_abort", 32'(n), 32'd0);
        start_op(8'h40, 8'h41, 1'b1);
        wait_done(1'b0, lat);
        check("lat_after_abort", 32'(lat), 32'(W + 1));
        check("diff_after_abort", 32'(diff), 32'hFE);
        check("bo_after_abort", 32'(borrow_out), 32'd1);

        // start held high: back-to-back operations at the minimum interval
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        last = -1; pulses = 0;
        for (int cyc = 0; cyc < 5 * (W + 2); cyc++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("diff_cont", 32'(diff), 32'h0F);
                if (last >= 0) check("cont_interval", 32'(cyc - last), 32'(W + 2));
                last = cyc;
            end
        end
        start = 1'b0;
        check("cont_pulses_ge4", 32'(pulses >= 4), 32'd1);
        repeat (W + 3) @(negedge clk);

        // randomized operands, with input noise while busy
        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            ea = r[W-1:0]; eb = r[2*W-1:W]; ebin = r[31];
            start_op(ea, eb, ebin);
            wait_done(1'b1, lat);
            t = int'(ea) - int'(eb) - int'(ebin);
            check("rnd_lat", 32'(lat), 32'(W + 1));
            check("rnd_diff", 32'(diff), 32'(t[W-1:0]));
            check("rnd_bo", 32'(borrow_out), 32'(t < 0));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
